mat_mult_seq: RTL

//  Operand sequencer and result collector for the 4-element row x column dot-product unit.

---
 rtl/mat_mult_seq.sv | 193 +++++++++++++++++++
 1 files changed

// File: rtl/mat_mult_seq.sv
`default_nettype none
// ============================================================================
// Module      : mat_mult_seq
// Description : Operand sequencer and result collector for a 4-element
//               row x column dot-product unit. Loads 4x4 A and B matrices
//               serially, issues all 16 (row, column) operand sets in
//               i-outer / j-inner order, captures the unit's registered sum
//               and streams the 16 results out over a valid/ready port.
// Revision    : 1.0 - initial release
// ============================================================================
module mat_mult_seq #(
    parameter int WIDTH_A_80 = 9,
    parameter int WIDTH_B_80 = 8,
    parameter int WIDTH_SUM  = 11
) (
    input  logic                  clk_80,
    input  logic                  rst_80,
    input  logic                  start_80,
    input  logic                  ld_valid_80,
    output logic                  ld_ready_80,
    input  logic [WIDTH_A_80-1:0] ld_data_80,
    output logic [WIDTH_A_80-1:0] A0_80,
    output logic [WIDTH_A_80-1:0] A1_80,
    output logic [WIDTH_A_80-1:0] A2_80,
    output logic [WIDTH_A_80-1:0] A3_80,
    output logic [WIDTH_B_80-1:0] B0_80,
    output logic [WIDTH_B_80-1:0] B1_80,
    output logic [WIDTH_B_80-1:0] B2_80,
    output logic [WIDTH_B_80-1:0] B3_80,
    input  logic [WIDTH_SUM-1:0]  ab_in_80,
    output logic                  res_valid_80,
    input  logic                  res_ready_80,
    output logic [WIDTH_SUM-1:0]  res_data_80,
    output logic                  res_last_80,
    output logic                  busy_80
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_LOAD_A  = 3'd1,
        S_LOAD_B  = 3'd2,
        S_ISSUE   = 3'd3,
        S_CAPTURE = 3'd4,
        S_OUT     = 3'd5
    } state_t;

    state_t                r_state;
    logic [3:0]            r_cnt;       // element index within the matrix being loaded
    logic [1:0]            r_i;         // current result row
    logic [1:0]            r_j;         // current result column

    // Matrix storage, row-major: element [r][c] lives at index {r, c}
    logic [WIDTH_A_80-1:0] r_mem_a [16];
    logic [WIDTH_B_80-1:0] r_mem_b [16];

    logic                  w_ld_hs;
    logic                  w_last_ld;
    logic [3:0]            w_pos;
    logic [1:0]            w_nxt_i;
    logic [1:0]            w_nxt_j;
    logic                  w_op_load;
    logic                  w_op_clear;

    assign w_ld_hs   = ld_valid_80 & ld_ready_80;
    assign w_last_ld = (r_cnt == 4'd15);

    // Position of the next (i,j) to issue: (0,0) when leaving the load phase,
    // otherwise the successor of the result just handed off.
    always_comb begin
        w_pos = 4'd0;
        if (r_state == S_OUT) begin
            w_pos = {r_i, r_j} + 4'd1;
        end
    end

    assign w_nxt_i = w_pos[3:2];
    assign w_nxt_j = w_pos[1:0];

    // Operands are refreshed exactly on the edge that enters ISSUE and are
    // dropped to zero on the edge that returns to IDLE.
    assign w_op_load  = ((r_state == S_LOAD_B) && w_ld_hs && w_last_ld) ||
                        ((r_state == S_OUT) && res_ready_80 && !res_last_80);
    assign w_op_clear = (r_state == S_OUT) && res_ready_80 && res_last_80;

    // Element store; storage is deliberately left out of reset.
    always_ff @(posedge clk_80) begin
        if (!rst_80 && w_ld_hs) begin
            if (r_state == S_LOAD_A) begin
                r_mem_a[r_cnt] <= ld_data_80;
            end else begin
                r_mem_b[r_cnt] <= ld_data_80[WIDTH_B_80-1:0];
            end
        end
    end

    // Operand registers: row i of A and column j of B.
    always_ff @(posedge clk_80) begin
        if (rst_80 || w_op_clear) begin
            A0_80 <= '0;
            A1_80 <= '0;
            A2_80 <= '0;
            A3_80 <= '0;
            B0_80 <= '0;
            B1_80 <= '0;
            B2_80 <= '0;
            B3_80 <= '0;
        end else if (w_op_load) begin
            A0_80 <= r_mem_a[{w_nxt_i, 2'd0}];
            A1_80 <= r_mem_a[{w_nxt_i, 2'd1}];
            A2_80 <= r_mem_a[{w_nxt_i, 2'd2}];
            A3_80 <= r_mem_a[{w_nxt_i, 2'd3}];
            B0_80 <= r_mem_b[{2'd0, w_nxt_j}];
            B1_80 <= r_mem_b[{2'd1, w_nxt_j}];
            B2_80 <= r_mem_b[{2'd2, w_nxt_j}];
            B3_80 <= r_mem_b[{2'd3, w_nxt_j}];
        end
    end

    // Control FSM with registered handshake and status outputs.
    always_ff @(posedge clk_80) begin
        if (rst_80) begin
            r_state      <= S_IDLE;
            r_cnt        <= 4'd0;
            r_i          <= 2'd0;
            r_j          <= 2'd0;
            ld_ready_80  <= 1'b0;
            res_valid_80 <= 1'b0;
            res_data_80  <= '0;
            res_last_80  <= 1'b0;
            busy_80      <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start_80) begin
                        r_state     <= S_LOAD_A;
                        r_cnt       <= 4'd0;
                        ld_ready_80 <= 1'b1;
                        busy_80     <= 1'b1;
                    end
                end
                S_LOAD_A: begin
                    if (w_ld_hs) begin
                        r_cnt <= r_cnt + 4'd1;
                        if (w_last_ld) begin
                            r_state <= S_LOAD_B;
                        end
                    end
                end
                S_LOAD_B: begin
                    if (w_ld_hs) begin
                        r_cnt <= r_cnt + 4'd1;
                        if (w_last_ld) begin
                            r_state     <= S_ISSUE;
                            ld_ready_80 <= 1'b0;
                            r_i         <= 2'd0;
                            r_j         <= 2'd0;
                        end
                    end
                end
                S_ISSUE: begin
                    r_state <= S_CAPTURE;
                end
                S_CAPTURE: begin
                    res_data_80  <= ab_in_80;
                    res_valid_80 <= 1'b1;
                    res_last_80  <= (r_i == 2'd3) && (r_j == 2'd3);
                    r_state      <= S_OUT;
                end
                S_OUT: begin
                    if (res_ready_80) begin
                        res_valid_80 <= 1'b0;
                        res_last_80  <= 1'b0;
                        if (res_last_80) begin
                            r_state <= S_IDLE;
                            busy_80 <= 1'b0;
                            r_i     <= 2'd0;
                            r_j     <= 2'd0;
                        end else begin
                            r_state <= S_ISSUE;
                            r_i     <= w_nxt_i;
                            r_j     <= w_nxt_j;
                        end
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
